seq_alu: RTL
============

# seq_alu

Parametrised, handshaked successor to the processor's combinational ALU. It is selected by the same 4-bit ALUCnt encoding, extended with signed compare, arithmetic shift, XOR/NOR and iterative multi-cycle unsigned multiply and divide. All outputs are registered, and results are held until the consumer accepts them. It sits in the EX stage; the stall logic stalls the pipeline on in_ready/out_valid.

## Interface

Parameters:

- WIDTH, 32, operand/result width; must be ≥ 4.
- SHAMT_W, 5, shift-amount width; only the low $clog2(WIDTH) bits are used.

Ports:

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- input1  in  WIDTH  operand A.
- input2  in  WIDTH  operand B.
- ALUCnt  in  4  operation select.
- shamt  in  SHAMT_W  shift amount.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result (product low half or quotient for mul/div).
- hi  out  WIDTH  product high half or remainder; 0 for other ops.
- zero  out  1  result == 0.
- illegal  out  1  unsupported ALUCnt was issued.

## Operation

- ALUCnt encoding:
  - 0000 add, 0001 sub (both modulo 2^WIDTH).
  - 0010 ~input1.
  - 0011 input1 << shamt, 0100 input1 >> shamt (logical).
  - 0101 and, 0110 or.
  - 0111 unsigned less-than (1/0, zero-extended).
  - 1000 input1 >>> shamt (arithmetic), 1001 signed less-than.
  - 1010 xor, 1011 nor.
  - 1100 MULTU, 1101 DIVU.
  - 1110/1111 illegal.
- Shifts use shamt mod WIDTH.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. An accept (in_valid && in_ready) latches the operands and ALUCnt.
    - Single-cycle op: result computed, go to DONE.
    - MULTU/DIVU: go to BUSY, iteration counter = 0.
  - BUSY: one radix-2 step per cycle for exactly WIDTH cycles, then DONE. in_ready=0.
    - MULTU: shift-add multiplication; {hi,result} = input1*input2 (2·WIDTH unsigned product).
    - DIVU: restoring division; result = quotient, hi = remainder.
  - DONE: out_valid=1; result/hi/zero/illegal held stable. Go to IDLE on out_ready=1, else stay.
- DIVU with input2==0: result = all ones, hi = input1, illegal=0, full WIDTH cycles taken.
- Illegal ALUCnt: result=0, hi=0, zero=1, illegal=1; handled as a single-cycle op.
- zero and illegal are registered alongside result and are valid only while out_valid=1.
- Inputs are ignored when in_ready=0. Operand changes after accept have no effect.

## Timing

- Reset (rst=1 at a rising edge): state=IDLE, in_ready=1, out_valid=0, result=0, hi=0, zero=0, illegal=0, iteration counter=0. Reset aborts any in-flight BUSY/DONE operation; no result is emitted.
- Single-cycle op:
  - accepted at edge N → out_valid=1 after edge N+1 … correction: accepted at edge N, out_valid=1 immediately after edge N, and in_ready=0 at the same time.
  - Earliest next accept is at edge N+2, when out_ready=1 during cycle N+1. Peak throughput is 1 op per 2 cycles.
- MULTU/DIVU: accepted at edge N → out_valid=1 after edge N+WIDTH+1 (WIDTH=32: 33 cycles).
- out_ready while out_valid=0 is ignored.
- in_ready is a pure function of state (IDLE), with no combinational path from in_valid or out_ready.
- rst and an accept in the same cycle: rst wins.

## Configuration

- SEQ_ALU_DIV_EN defined: DIVU is implemented as described above.
- Not defined: no divider datapath is generated. 1101 is treated as illegal (single-cycle, illegal=1, result=0, hi=0). MULTU is unaffected.

## Test plan

- Reset, then add 0x7FFFFFFF+1 with out_ready=1 → after the accept edge out_valid=1, result=0x80000000, zero=0. in_ready returns 1 on the following cycle.
- sub 5−5 → result=0, zero=1. Signed slt (1001) with 0xFFFFFFFF vs 1 → result=1. Unsigned slt (0111) with the same operands → result=0. sra 0x80000000 by 4 → 0xF8000000.
- MULTU 0xFFFFFFFF×0xFFFFFFFF with out_ready=0 → out_valid rises exactly 33 cycles after the accept, result=0x00000001, hi=0xFFFFFFFE. Values held stable for 10 cycles, in_ready=0 throughout. Raising out_ready drops out_valid next edge.
- DIVU 100÷7 → result=14, hi=2. DIVU 9÷0 → result=0xFFFFFFFF, hi=9. Without SEQ_ALU_DIV_EN: DIVU 100÷7 → illegal=1, result=0, hi=0, 1-cycle latency.
- ALUCnt=1110 → illegal=1, zero=1, result=0. rst asserted in the 10th BUSY cycle of a MULTU → next cycle in_ready=1, out_valid=0, result=0, hi=0, and no result is ever produced.
- WIDTH=8 instance: MULTU 200×3 → result=0x58, hi=0x02 after 9 cycles. sll 0x81 by shamt=9 → shift by 1, result=0x02.

Source files
------------

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_if
//  Brief    : Request/result handshake bundle for the sequential ALU.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   input1;
    logic [WIDTH-1:0]   input2;
    logic [3:0]         ALUCnt;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [WIDTH-1:0]   hi;
    logic               zero;
    logic               illegal;

    modport master (
        output in_valid, input1, input2, ALUCnt, shamt, out_ready,
        input  in_ready, out_valid, result, hi, zero, illegal
    );

    modport slave (
        input  in_valid, input1, input2, ALUCnt, shamt, out_ready,
        output in_ready, out_valid, result, hi, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu
//  Brief    : Handshaked ALU with iterative MULTU/DIVU; registered results.
//             Define SEQ_ALU_DIV_EN to build the restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic  clk,
    input  wire logic  rst,
    seq_alu_if.slave   bus
);
    localparam int c_SW = $clog2(WIDTH);
    localparam int c_CW = $clog2(WIDTH + 1);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_NOT  = 4'b0010;
    localparam logic [3:0] c_OP_SLL  = 4'b0011;
    localparam logic [3:0] c_OP_SRL  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_OR   = 4'b0110;
    localparam logic [3:0] c_OP_SLTU = 4'b0111;
    localparam logic [3:0] c_OP_SRA  = 4'b1000;
    localparam logic [3:0] c_OP_SLT  = 4'b1001;
    localparam logic [3:0] c_OP_XOR  = 4'b1010;
    localparam logic [3:0] c_OP_NOR  = 4'b1011;
    localparam logic [3:0] c_OP_MULU = 4'b1100;
    localparam logic [3:0] c_OP_DIVU = 4'b1101;

`ifdef SEQ_ALU_DIV_EN
    localparam bit c_DIV_EN = 1'b1;
`else
    localparam bit c_DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_b;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic               r_zero;
    logic               r_illegal;

    logic [c_SW-1:0]    w_sh;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_ill;
    logic               w_multi;
    logic               w_last;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH-1:0]   w_div_hi;
    logic [WIDTH-1:0]   w_div_lo;
    logic               w_op_div;
    logic               w_unused;

    generate
        if (SHAMT_W >= c_SW) begin : g_sh_trunc
            assign w_sh = bus.shamt[c_SW-1:0];
        end else begin : g_sh_ext
            assign w_sh = {{(c_SW - SHAMT_W){1'b0}}, bus.shamt};
        end
    endgenerate

    always_comb begin
        w_alu_res = '0;
        w_alu_ill = 1'b0;
        case (bus.ALUCnt)
            c_OP_ADD:  w_alu_res = bus.input1 + bus.input2;
            c_OP_SUB:  w_alu_res = bus.input1 - bus.input2;
            c_OP_NOT:  w_alu_res = ~bus.input1;
            c_OP_SLL:  w_alu_res = bus.input1 << w_sh;
            c_OP_SRL:  w_alu_res = bus.input1 >> w_sh;
            c_OP_AND:  w_alu_res = bus.input1 & bus.input2;
            c_OP_OR:   w_alu_res = bus.input1 | bus.input2;
            c_OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
            c_OP_SRA:  w_alu_res = $signed(bus.input1) >>> w_sh;
            c_OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}},
                                    ($signed(bus.input1) < $signed(bus.input2))};
            c_OP_XOR:  w_alu_res = bus.input1 ^ bus.input2;
            c_OP_NOR:  w_alu_res = ~(bus.input1 | bus.input2);
            c_OP_MULU: w_alu_res = '0;
            c_OP_DIVU: w_alu_ill = ~c_DIV_EN;
            default:   w_alu_ill = 1'b1;
        endcase
    end

    assign w_multi = (bus.ALUCnt == c_OP_MULU) || (c_DIV_EN && (bus.ALUCnt == c_OP_DIVU));
    assign w_last  = (r_cnt == c_CW'(WIDTH));

    // Shift-add: r_hi accumulates, r_result holds the multiplier and
    // receives product bits from the top as it shifts right.
    assign w_mul_sum = {1'b0, r_hi} + (r_result[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});

`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH:0] w_rem_sh;
    logic [WIDTH:0] w_diff;
    assign w_rem_sh = {r_hi, r_result[WIDTH-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_b};
    assign w_div_hi = w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_div_lo = {r_result[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_op_div = (r_op == c_OP_DIVU);
`else
    assign w_div_hi = r_hi;
    assign w_div_lo = r_result;
    assign w_op_div = 1'b0;
`endif

    assign w_unused = ^{bus.shamt, r_op};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.in_valid) w_state_next = w_multi ? S_BUSY : S_DONE;
            S_BUSY: if (w_last)       w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op      <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_hi      <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op <= bus.ALUCnt;
                        if (w_multi) begin
                            r_cnt     <= '0;
                            r_hi      <= '0;
                            r_zero    <= 1'b0;
                            r_illegal <= 1'b0;
                            if (bus.ALUCnt == c_OP_MULU) begin
                                r_b      <= bus.input1;
                                r_result <= bus.input2;
                            end else begin
                                r_b      <= bus.input2;
                                r_result <= bus.input1;
                            end
                        end else begin
                            r_result  <= w_alu_res;
                            r_hi      <= '0;
                            r_zero    <= (w_alu_res == '0);
                            r_illegal <= w_alu_ill;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_last) begin
                        r_zero <= (r_result == '0);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_op_div) begin
                            r_hi     <= w_div_hi;
                            r_result <= w_div_lo;
                        end else begin
                            r_hi     <= w_mul_sum[WIDTH:1];
                            r_result <= {w_mul_sum[0], r_result[WIDTH-1:1]};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.hi        = r_hi;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire
